// File: rtl/traffic_pkg.sv
// traffic_pkg: state encoding, lamp patterns and led bit positions for the crossing sequencer
package traffic_pkg;
  typedef enum logic [2:0] {IDLE, GO_NOPD, WAIT_NOPD, ALLRED_A, GO_PD, WAIT_PD, ALLRED_B} state_t;
  localparam int LED_CAR_G = 5;
  localparam int LED_CAR_Y = 4;
  localparam int LED_CAR_R = 3;
  localparam int LED_PED_G = 2;
  localparam int LED_PED_Y = 1;
  localparam int LED_PED_R = 0;
  localparam logic [5:0] LAMP_IDLE      = 6'(1 << LED_CAR_R) | 6'(1 << LED_PED_R);
  localparam logic [5:0] LAMP_GO_NOPD   = 6'(1 << LED_CAR_G) | 6'(1 << LED_PED_R);
  localparam logic [5:0] LAMP_WAIT_NOPD = 6'(1 << LED_CAR_Y) | 6'(1 << LED_PED_R);
  localparam logic [5:0] LAMP_ALLRED_A  = 6'(1 << LED_CAR_R) | 6'(1 << LED_PED_R);
  localparam logic [5:0] LAMP_GO_PD     = 6'(1 << LED_CAR_R) | 6'(1 << LED_PED_G);
  localparam logic [5:0] LAMP_WAIT_PD   = 6'(1 << LED_CAR_R) | 6'(1 << LED_PED_Y);
  localparam logic [5:0] LAMP_ALLRED_B  = 6'(1 << LED_CAR_R) | 6'(1 << LED_PED_R);
  function automatic logic [5:0] lamp(input state_t s);
    return s == GO_NOPD   ? LAMP_GO_NOPD :
           s == WAIT_NOPD ? LAMP_WAIT_NOPD :
           s == ALLRED_A  ? LAMP_ALLRED_A :
           s == GO_PD     ? LAMP_GO_PD :
           s == WAIT_PD   ? LAMP_WAIT_PD :
           s == ALLRED_B  ? LAMP_ALLRED_B : LAMP_IDLE;
  endfunction
endpackage

// File: rtl/traffic_phase_scheduler_tick_gen.sv
// tick_gen: free-running divider emitting one tick every TICK_DIV cycles, restartable by clr
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: pedestrian crossing phase sequencer; define TPS_AUTO_CYCLE_EN to cap vehicle green at T_MAX_CAR
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int T_GREEN_CAR  = 10,
  parameter int T_MAX_CAR    = 30,
  parameter int T_YELLOW_CAR = 3,
  parameter int T_ALLRED     = 2,
  parameter int T_GREEN_PED  = 8,
  parameter int T_YELLOW_PED = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw,
  input  logic       ped_req,
  output logic [5:0] led,
  output logic       start_pd,
  output logic       start_nopd,
  output logic       ped_wait,
  output logic [7:0] remain
);
  if (TICK_DIV < 2 || T_GREEN_CAR < 1 || T_GREEN_CAR > 255 || T_MAX_CAR < 1 || T_MAX_CAR > 255 ||
      T_YELLOW_CAR < 1 || T_YELLOW_CAR > 255 || T_ALLRED < 1 || T_ALLRED > 255 ||
      T_GREEN_PED < 1 || T_GREEN_PED > 255 || T_YELLOW_PED < 1 || T_YELLOW_PED > 255) begin : g_bad_param
    $error("traffic_phase_scheduler: parameter out of range");
  end
  state_t     state, nxt;
  logic       tick, chg, expire, green_ok, max_ok, enter_pd, enter_nopd, pw_d;
  logic [7:0] elapsed, el_n, load;
  logic [5:0] led_d;
  assign chg = nxt != state;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (chg),
    .tick(tick)
  );
  assign expire   = tick && remain == 8'd1;
  assign el_n     = elapsed + 8'(tick && elapsed != 8'hff);
  assign green_ok = el_n >= 8'(T_GREEN_CAR);
`ifdef TPS_AUTO_CYCLE_EN
  assign max_ok = el_n >= 8'(T_MAX_CAR);
`else
  assign max_ok = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      led        <= LAMP_IDLE;
      start_pd   <= 1'b0;
      start_nopd <= 1'b0;
      ped_wait   <= 1'b0;
      remain     <= 8'd0;
      elapsed    <= 8'd0;
    end else begin
      state      <= nxt;
      led        <= led_d;
      start_pd   <= enter_pd;
      start_nopd <= enter_nopd;
      ped_wait   <= pw_d;
      remain     <= chg ? load : (tick && remain != 8'd0) ? remain - 1'b1 : remain;
      elapsed    <= chg ? 8'd0 : state == GO_NOPD ? el_n : elapsed;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = sw ? GO_NOPD : IDLE;
      GO_NOPD:   nxt = (!sw || (ped_wait && green_ok) || max_ok) ? WAIT_NOPD : GO_NOPD;
      WAIT_NOPD: nxt = expire ? ALLRED_A : WAIT_NOPD;
      ALLRED_A:  nxt = expire ? (sw ? GO_PD : IDLE) : ALLRED_A;
      GO_PD:     nxt = (expire || !sw) ? WAIT_PD : GO_PD;
      WAIT_PD:   nxt = expire ? ALLRED_B : WAIT_PD;
      ALLRED_B:  nxt = expire ? (sw ? GO_NOPD : IDLE) : ALLRED_B;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    led_d      = lamp(nxt);
    enter_pd   = nxt == GO_PD && state != GO_PD;
    enter_nopd = nxt == GO_NOPD && state != GO_NOPD;
    pw_d       = enter_pd ? 1'b0 : (ped_req && state != GO_PD && state != WAIT_PD) ? 1'b1 : ped_wait;
    load       = nxt == GO_NOPD   ? 8'(T_GREEN_CAR) :
                 nxt == WAIT_NOPD ? 8'(T_YELLOW_CAR) :
                 nxt == GO_PD     ? 8'(T_GREEN_PED) :
                 nxt == WAIT_PD   ? 8'(T_YELLOW_PED) :
                 (nxt == ALLRED_A || nxt == ALLRED_B) ? 8'(T_ALLRED) : 8'd0;
  end
endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed and randomized checks against a cycle-counting phase model
module tb_traffic_phase_scheduler;
  localparam int DIV = 4, TG = 3, TYC = 2, TAR = 1, TGP = 3, TYP = 2, TMX = 8;
`ifdef TPS_AUTO_CYCLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0, rst, sw, ped_req;
  logic [5:0] led;
  logic start_pd, start_nopd, ped_wait;
  logic [7:0] remain;
  int total = 0, bad = 0;
  int dur[7] = '{0, 0, TYC, TAR, TGP, TYP, TAR};
  logic [5:0] pat[7] = '{6'b001001, 6'b100001, 6'b010001, 6'b001001, 6'b001100, 6'b001010, 6'b001001};
  int m_st = 0, m_cyc = 0, nx, exp_rem, n;
  bit m_pw = 0, m_spd = 0, m_snopd = 0, armed = 0, done;

  traffic_phase_scheduler #(
    .TICK_DIV(DIV), .T_GREEN_CAR(TG), .T_MAX_CAR(TMX), .T_YELLOW_CAR(TYC),
    .T_ALLRED(TAR), .T_GREEN_PED(TGP), .T_YELLOW_PED(TYP)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .ped_req(ped_req), .led(led),
    .start_pd(start_pd), .start_nopd(start_nopd), .ped_wait(ped_wait), .remain(remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic count_while(input logic [5:0] p, input int bound, output int cnt);
    cnt = 0;
    while (led == p && cnt < bound) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // phases: 0 idle, 1 car green, 2 car yellow, 3 all-red A, 4 ped green, 5 ped yellow, 6 all-red B
  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_cyc = 0; m_pw = 0; m_spd = 0; m_snopd = 0;
    end else begin
      done = dur[m_st] != 0 && (m_cyc + 1) == dur[m_st] * DIV;
      nx = m_st;
      case (m_st)
        0: if (sw) nx = 1;
        1: if (!sw || (m_pw && (m_cyc + 1) >= TG * DIV) || (AUTO && (m_cyc + 1) >= TMX * DIV)) nx = 2;
        2: if (done) nx = 3;
        3: if (done) nx = sw ? 4 : 0;
        4: if (done || !sw) nx = 5;
        5: if (done) nx = 6;
        default: if (done) nx = sw ? 1 : 0;
      endcase
      m_spd = nx == 4 && m_st != 4;
      m_snopd = nx == 1 && m_st != 1;
      if (m_spd) m_pw = 0;
      else if (ped_req && m_st != 4 && m_st != 5) m_pw = 1;
      m_cyc = (nx != m_st) ? 0 : m_cyc + 1;
      m_st = nx;
    end
    armed = 1;
  end

  always @(negedge clk) if (armed) begin
    exp_rem = m_st == 0 ? 0 : m_st == 1 ? ((TG - m_cyc / DIV) > 0 ? TG - m_cyc / DIV : 0) : dur[m_st] - m_cyc / DIV;
    chk("model_led", led, pat[m_st]);
    chk("model_remain", remain, exp_rem);
    chk("model_ped_wait", ped_wait, m_pw);
    chk("model_start_pd", start_pd, m_spd);
    chk("model_start_nopd", start_nopd, m_snopd);
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; sw = 0; ped_req = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_led", led, 6'b001001);
      chk("idle_remain", remain, 0);
      chk("idle_ped_wait", ped_wait, 0);
    end
    sw = 1;
    @(negedge clk);
    chk("go_nopd_led", led, 6'b100001);
    chk("go_nopd_strobe", start_nopd, 1);
    chk("go_nopd_remain", remain, TG);
    @(negedge clk);
    chk("go_nopd_strobe_once", start_nopd, 0);
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
    chk("ped_wait_set", ped_wait, 1);
    count_while(6'b100001, 100, n);
    chk("green_len", n + 2, 12);
    chk("wait_nopd_led", led, 6'b010001);
    count_while(6'b010001, 100, n);
    chk("wait_nopd_len", n, 8);
    count_while(6'b001001, 100, n);
    chk("allred_a_len", n, 4);
    chk("go_pd_led", led, 6'b001100);
    chk("go_pd_strobe", start_pd, 1);
    chk("go_pd_ped_clear", ped_wait, 0);
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
    chk("go_pd_ignore_req", ped_wait, 0);
    chk("go_pd_strobe_once", start_pd, 0);
    count_while(6'b001100, 100, n);
    chk("go_pd_len", n + 1, 12);
    count_while(6'b001010, 100, n);
    chk("wait_pd_len", n, 8);
    count_while(6'b001001, 100, n);
    chk("allred_b_len", n, 4);
    chk("cycle_back_led", led, 6'b100001);
    chk("cycle_back_strobe", start_nopd, 1);
    chk("cycle_back_ped_wait", ped_wait, 0);
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
    count_while(6'b100001, 100, n);
    count_while(6'b010001, 100, n);
    count_while(6'b001001, 100, n);
    chk("second_go_pd", led, 6'b001100);
    repeat (2) @(negedge clk);
    sw = 0;
    @(negedge clk);
    chk("sw_drop_wait_pd", led, 6'b001010);
    count_while(6'b001010, 100, n);
    chk("sw_drop_wait_pd_len", n, 8);
    repeat (30) @(negedge clk);
    chk("sw_drop_idle_led", led, 6'b001001);
    chk("sw_drop_idle_remain", remain, 0);
    sw = 1;
    @(negedge clk);
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
    count_while(6'b100001, 100, n);
    repeat (2) @(negedge clk);
    chk("pre_rst_led", led, 6'b010001);
    chk("pre_rst_ped_wait", ped_wait, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_led", led, 6'b001001);
    chk("rst_remain", remain, 0);
    chk("rst_ped_wait", ped_wait, 0);
    chk("rst_strobes", {start_pd, start_nopd}, 0);
    rst = 0; sw = 0;
    repeat (5) @(negedge clk);
    sw = 1;
    @(negedge clk);
    count_while(6'b100001, 1100, n);
    chk("green_hold_len", n, AUTO ? TMX * DIV : 1100);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      ped_req = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 199) == 0) sw = !sw;
      rst = $urandom_range(0, 999) == 0;
    end
    rst = 0; sw = 0; ped_req = 0;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
